// File: rtl/pipe_stage_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg_pkg
// Description : Shared constants and stage-action decode for the 5-stage CPU
//               pipeline registers.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_stage_reg_pkg;

    localparam logic       c_STOP          = 1'b1;
    localparam logic       c_NO_STOP       = 1'b0;
    localparam logic       c_RST_ENABLE    = 1'b1;
    localparam logic       c_WRITE_DISABLE = 1'b0;
    localparam logic [4:0] c_NOP_REG_ADDR  = 5'b00000;
    localparam logic [7:0] c_EXE_NOP_OP    = 8'b0000_0000;

    localparam int c_STG_IF  = 0;
    localparam int c_STG_ID  = 1;
    localparam int c_STG_EX  = 2;
    localparam int c_STG_MEM = 3;
    localparam int c_STG_WB  = 4;

    // Payload widths carried across each pipeline boundary
    localparam int c_IF_ID_W  = 32;
    localparam int c_ID_EX_W  = 64;
    localparam int c_EX_MEM_W = 16;
    localparam int c_MEM_WB_W = 24;

    typedef enum logic [1:0] {
        ACT_ADVANCE = 2'd0,
        ACT_BUBBLE  = 2'd1,
        ACT_HOLD    = 2'd2,
        ACT_FLUSH   = 2'd3
    } stage_action_t;

    function automatic stage_action_t decode_action(input logic flush,
                                                    input logic stop_here,
                                                    input logic stop_next);
        stage_action_t act;
        if (flush)
            act = ACT_FLUSH;
        else if (stop_here == c_STOP && stop_next == c_NO_STOP)
            act = ACT_BUBBLE;
        else if (stop_here == c_NO_STOP)
            act = ACT_ADVANCE;
        else
            act = ACT_HOLD;
        return act;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage_reg_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at its all-ones maximum; clr has
//               priority over inc.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] c_MAX = {W{1'b1}};

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (clr)
            r_cnt <= '0;
        else if (inc && r_cnt != c_MAX)
            r_cnt <= r_cnt + W'(1);
    end

    assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Parametrised inter-stage pipeline register with valid bit,
//               flush, bubble insertion and saturating hold-length counter.
//               Define PIPE_STAGE_PERF_EN to build bubble/flush counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int                DATA_W    = 16,
    parameter int                STALL_W   = 6,
    parameter int                STAGE     = 3,
    parameter logic [DATA_W-1:0] NOP_VALUE = '0,
    parameter int                HOLD_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic [HOLD_W-1:0]  hold_len,
    output logic [15:0]        bubble_cnt,
    output logic [15:0]        flush_cnt
);

    import pipe_stage_reg_pkg::*;

    generate
        if (STAGE < 0 || STAGE > STALL_W - 2) begin : g_bad_stage
            $error("pipe_stage_reg: STAGE must lie in 0..STALL_W-2");
        end
    endgenerate

    stage_action_t     w_action;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    // Only this stage's bit and the downstream neighbour's bit matter
    logic w_unused_stall;
    assign w_unused_stall = ^stall;

    assign w_action = decode_action(flush, stall[STAGE], stall[STAGE+1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= NOP_VALUE;
        end else begin
            case (w_action)
                ACT_FLUSH, ACT_BUBBLE: begin
                    r_valid <= 1'b0;
                    r_data  <= NOP_VALUE;
                end
                ACT_ADVANCE: begin
                    r_valid <= in_valid;
                    r_data  <= in_data;
                end
                default: begin
                    r_valid <= r_valid;
                    r_data  <= r_data;
                end
            endcase
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;

    sat_counter #(.W(HOLD_W)) u_hold_cnt (
        .clk (clk),
        .rst (rst),
        .clr (w_action != ACT_HOLD),
        .inc (w_action == ACT_HOLD),
        .cnt (hold_len)
    );

`ifdef PIPE_STAGE_PERF_EN
    sat_counter #(.W(16)) u_bubble_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (w_action == ACT_BUBBLE),
        .cnt (bubble_cnt)
    );

    sat_counter #(.W(16)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (w_action == ACT_FLUSH),
        .cnt (flush_cnt)
    );
`else
    assign bubble_cnt = 16'h0000;
    assign flush_cnt  = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Self-checking bench for pipe_stage_reg against a cycle-level
//               behavioural model (STAGE=3, STALL_W=6, DATA_W=16, HOLD_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int DATA_W  = 16;
    localparam int STALL_W = 6;
    localparam int STAGE   = 3;
    localparam int HOLD_W  = 4;
    localparam logic [DATA_W-1:0] NOP = 16'h0000;

    logic               clk = 1'b0;
    logic               rst;
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic               in_valid;
    logic [DATA_W-1:0]  in_data;
    logic               out_valid;
    logic [DATA_W-1:0]  out_data;
    logic [HOLD_W-1:0]  hold_len;
    logic [15:0]        bubble_cnt;
    logic [15:0]        flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    int m_valid, m_data, m_hold, m_bub, m_fl;

    pipe_stage_reg #(
        .DATA_W   (DATA_W),
        .STALL_W  (STALL_W),
        .STAGE    (STAGE),
        .NOP_VALUE(NOP),
        .HOLD_W   (HOLD_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .hold_len  (hold_len),
        .bubble_cnt(bubble_cnt),
        .flush_cnt (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int observed, input int expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic check_all(input string phase);
        int exp_bub, exp_fl;
`ifdef PIPE_STAGE_PERF_EN
        exp_bub = m_bub;
        exp_fl  = m_fl;
`else
        exp_bub = 0;
        exp_fl  = 0;
`endif
        check_val({phase, ".out_valid"},  int'(out_valid),  m_valid);
        check_val({phase, ".out_data"},   int'(out_data),   m_data);
        check_val({phase, ".hold_len"},   int'(hold_len),   m_hold);
        check_val({phase, ".bubble_cnt"}, int'(bubble_cnt), exp_bub);
        check_val({phase, ".flush_cnt"},  int'(flush_cnt),  exp_fl);
    endtask

    function automatic int sat_inc(input int v, input int max);
        return (v >= max) ? max : v + 1;
    endfunction

    // Apply one cycle of inputs; outputs must not move before the edge
    task automatic step(input string phase, input logic r, input logic [STALL_W-1:0] s,
                        input logic f, input logic v, input logic [DATA_W-1:0] d);
        @(negedge clk);
        rst = r; stall = s; flush = f; in_valid = v; in_data = d;
        #1;
        check_val({phase, ".pre_edge_data"},  int'(out_data),  m_data);
        check_val({phase, ".pre_edge_valid"}, int'(out_valid), m_valid);
        @(posedge clk);
        if (r) begin
            m_valid = 0; m_data = int'(NOP); m_hold = 0; m_bub = 0; m_fl = 0;
        end else if (f) begin
            m_valid = 0; m_data = int'(NOP); m_hold = 0; m_fl = sat_inc(m_fl, 65535);
        end else if (s[STAGE] && !s[STAGE+1]) begin
            m_valid = 0; m_data = int'(NOP); m_hold = 0; m_bub = sat_inc(m_bub, 65535);
        end else if (!s[STAGE]) begin
            m_valid = int'(v); m_data = int'(d); m_hold = 0;
        end else begin
            m_hold = sat_inc(m_hold, (1 << HOLD_W) - 1);
        end
        #1;
        check_all(phase);
    endtask

    initial begin
        logic [STALL_W-1:0] rs;
        m_valid = 0; m_data = 0; m_hold = 0; m_bub = 0; m_fl = 0;
        rst = 1'b1; stall = '0; flush = 1'b0; in_valid = 1'b0; in_data = '0;

        step("reset", 1'b1, 6'b000000, 1'b0, 1'b1, 16'hABCD);
        step("reset", 1'b1, 6'b000000, 1'b0, 1'b1, 16'hABCD);
        check_val("reset.out_data_nop", int'(out_data), int'(NOP));

        step("advance", 1'b0, 6'b000000, 1'b0, 1'b1, 16'h1234);
        check_val("advance.loaded", int'(out_data), 32'h1234);

        step("bubble", 1'b0, 6'b001000, 1'b0, 1'b1, 16'h5555);
        step("reload", 1'b0, 6'b000000, 1'b0, 1'b1, 16'h1234);

        for (int i = 0; i < 20; i++)
            step("hold", 1'b0, 6'b011000, 1'b0, 1'b1, DATA_W'($urandom));
        check_val("hold.saturated", int'(hold_len), 15);
        check_val("hold.kept", int'(out_data), 32'h1234);

        step("release", 1'b0, 6'b000000, 1'b0, 1'b1, 16'h5678);
        step("invalid_adv", 1'b0, 6'b000000, 1'b0, 1'b0, 16'h9ABC);

        step("hold2", 1'b0, 6'b011000, 1'b0, 1'b1, 16'h1111);
        step("hold2", 1'b0, 6'b011000, 1'b0, 1'b1, 16'h2222);
        step("flush_hold", 1'b0, 6'b011000, 1'b1, 1'b1, 16'h3333);
        step("flush_rst", 1'b1, 6'b011000, 1'b1, 1'b1, 16'h4444);

        // Unused stall bits toggling must not matter
        step("unused_bits", 1'b0, 6'b100111, 1'b0, 1'b1, 16'hCAFE);
        step("unused_bits", 1'b0, 6'b110111, 1'b0, 1'b1, 16'hBEEF);

        for (int i = 0; i < 600; i++) begin
            rs = STALL_W'($urandom);
            if ($urandom_range(0, 2) == 0) rs[STAGE+1] = 1'b1;
            step("random",
                 ($urandom_range(0, 99) == 0),
                 rs,
                 ($urandom_range(0, 9) == 0),
                 1'($urandom),
                 DATA_W'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register for the 16-bit 5-stage CPU. It generalises the fixed EX/MEM register.
- Payload width, stage index in the stall vector and NOP payload value are parameters.
- Adds an explicit valid bit, a flush input and a saturating hold-length counter.
- One instance replaces each of IF/ID, ID/EX, EX/MEM and MEM/WB; fields are concatenated into one payload bus at the instance site.

Parameters:
DATA_W, 16, payload width in bits (1..256).
STALL_W, 6, width of the global stall vector from the control unit.
STAGE, 3, index of this register's upstream stage in stall; must satisfy 0 <= STAGE <= STALL_W-2, else elaboration error.
NOP_VALUE, 0, payload loaded on reset, bubble or flush (DATA_W bits).
HOLD_W, 4, width of the hold-length counter.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
stall  in  STALL_W  global stall vector; Stop=1, NoStop=0
flush  in  1  discard current contents (branch/exception), one-cycle pulse or level
in_valid  in  1  upstream instruction valid
in_data  in  DATA_W  upstream payload
out_valid  out  1  registered valid to downstream stage
out_data  out  DATA_W  registered payload
hold_len  out  HOLD_W  consecutive hold cycles, saturating
bubble_cnt  out  16  bubbles inserted (optional feature)
flush_cnt  out  16  flushes taken (optional feature)

Behaviour:
- Reset values: out_valid=0, out_data=NOP_VALUE, hold_len=0, bubble_cnt=0, flush_cnt=0.
- Single-cycle latency. All updates occur on the rising clk edge. Priority, highest first:
  1. rst=1: reset values.
  2. flush=1: out_valid=0, out_data=NOP_VALUE, hold_len=0, flush_cnt+1.
  3. stall[STAGE]=Stop and stall[STAGE+1]=NoStop (bubble): out_valid=0, out_data=NOP_VALUE, hold_len=0, bubble_cnt+1.
  4. stall[STAGE]=NoStop (advance): out_valid<=in_valid, out_data<=in_data, hold_len=0.
  5. Otherwise (both Stop, hold): outputs unchanged, hold_len+1.
- Flush overrides a simultaneous hold or bubble. A flush while holding discards the held instruction.
- Invalid payload: in_valid=0 on advance still loads in_data unmasked. Downstream must qualify on out_valid.
- Counter saturation: hold_len sticks at 2^HOLD_W-1. bubble_cnt and flush_cnt stick at 16'hFFFF; none of them wrap.
- Reset mid-hold or mid-flush: rst wins and clears everything the same cycle.
- Unused stall bits are ignored.
- Register behaviour: no combinational path from in_* to out_*. stall and flush do not affect outputs until the clock edge.

Optional Feature:
PIPE_STAGE_PERF_EN.
- Defined: bubble_cnt and flush_cnt are live saturating counters as described above.
- Undefined: no counter flops are built; both ports are tied to 16'h0000. All other behaviour is identical.

Decomposition:
- Shared define.v: Stop/NoStop, RstEnable, WriteDisable, NOPRegAddr and EXE_NOP_OP. Also add per-stage STAGE index constants (STG_IF=0 … STG_WB=4) and payload-width constants per boundary.
- One natural sub-module, sat_counter (parameter W; ports clk, rst, clr, inc, cnt). It is used for hold_len and both perf counters.

Test Plan:
1. Reset: rst=1 for 2 cycles with in_data=16'hABCD, in_valid=1 -> out_valid=0, out_data=NOP_VALUE, hold_len=0, counters 0.
2. Advance: STAGE=3, stall=6'b000000, in_data=16'h1234, in_valid=1 -> next cycle out_valid=1, out_data=16'h1234.
3. Bubble: stall=6'b001000 for 1 cycle after loading 16'h1234 -> out_valid=0, out_data=NOP_VALUE, bubble_cnt=1 (with macro).
4. Hold/saturation: stall=6'b011000 for 20 cycles with in_data changing -> out_data stays 16'h1234, hold_len counts 1..15 then stays 15. Release -> hold_len=0 and new data loads.
5. Flush priority: hold active (stall=6'b011000) with flush=1 for one cycle -> out_valid=0, out_data=NOP_VALUE, flush_cnt=1, hold_len=0. Then flush and rst together -> reset values, flush_cnt=0.
6. Macro off: repeat test 3 without PIPE_STAGE_PERF_EN -> bubble_cnt=flush_cnt=16'h0000, all other outputs identical to the macro-on run.
